// File: rtl/param_ram.sv
// param_ram: small parameter storage array with a registered read port,
// a single write port and a clear sweep that zeroes one word per cycle.
//
// Optional feature macro: PARAM_RAM_BYPASS_EN
//   defined   -> same-address read-during-write returns the new write data
//   undefined -> same-address read-during-write returns the old stored word
//
// Controller states:
//   state | meaning
//   IDLE  | normal operation, read/write/clear requests are accepted
//   SWEEP | zeroing the array, one word per cycle; all requests dropped

module param_ram #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              write,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              read,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata,
  output logic              rvalid,
  input  logic              clear,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  ptr_q, ptr_d;
  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [WIDTH-1:0]   rdata_q, rdata_d;
  logic               rvalid_q, rvalid_d;

  logic               idle;
  logic               clear_acc;
  logic               wr_acc;
  logic               rd_acc;
  logic               sweep_wr;

  // Request qualification: clear wins over read/write, everything dropped in SWEEP.
  always_comb begin
    idle      = (state_q == IDLE);
    clear_acc = idle && clear;
    wr_acc    = idle && en && write && !clear;
    rd_acc    = idle && en && read  && !clear;
    sweep_wr  = (state_q == SWEEP);
  end

  // Next-state logic for the clear controller and its sweep pointer.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (clear_acc) begin
          state_d = SWEEP;
          ptr_d   = '0;
        end
      end
      SWEEP: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == LAST_ADDR) begin
          state_d = IDLE;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  // Controller state and sweep pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Storage array: reset clears every word, sweep zeroes the word at the pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (sweep_wr) begin
      mem_q[ptr_q] <= '0;
    end else if (wr_acc) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read data selection; rdata holds when no read is accepted.
  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = rd_acc;
    if (rd_acc) begin
`ifdef PARAM_RAM_BYPASS_EN
      if (wr_acc && (waddr == raddr)) begin
        rdata_d = wdata;
      end else begin
        rdata_d = mem_q[raddr];
      end
`else
      rdata_d = mem_q[raddr];
`endif
    end
  end

  // Registered read port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign busy   = (state_q == SWEEP);

endmodule

// File: tb/tb_param_ram.sv
// Directed bench for param_ram (WIDTH=32, ADDR_W=3).
// Inputs change 1ns after the rising edge; outputs are sampled there too.

module tb_param_ram;

  localparam int WIDTH  = 32;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic              write;
  logic [ADDR_W-1:0] waddr;
  logic [WIDTH-1:0]  wdata;
  logic              read;
  logic [ADDR_W-1:0] raddr;
  logic [WIDTH-1:0]  rdata;
  logic              rvalid;
  logic              clear;
  logic              busy;

  int checks = 0;
  int errors = 0;

  param_ram #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .write  (write),
    .waddr  (waddr),
    .wdata  (wdata),
    .read   (read),
    .raddr  (raddr),
    .rdata  (rdata),
    .rvalid (rvalid),
    .clear  (clear),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    en = 1'b1; write = 1'b0; read = 1'b0; clear = 1'b0;
    waddr = '0; wdata = '0; raddr = '0;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
    write = 1'b1; waddr = a; wdata = d;
    cyc();
    write = 1'b0;
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a);
    read = 1'b1; raddr = a;
    cyc();
    read = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 40) begin
      cyc();
      n++;
    end
    check(tag, 64'(busy), 64'd0);
  endtask

  logic [WIDTH-1:0] exp_bypass;
  int               nbusy;

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    #12;
    check("reset_rdata", 64'(rdata), 64'd0);
    check("reset_rvalid", 64'(rvalid), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Read from a freshly reset array
    do_read(3'd5);
    check("rst_read5_data", 64'(rdata), 64'h0);
    check("rst_read5_valid", 64'(rvalid), 64'd1);
    cyc();
    check("rvalid_drop", 64'(rvalid), 64'd0);

    // Write then read back
    do_write(3'd3, 32'hDEADBEEF);
    do_read(3'd3);
    check("wr3_rd3_data", 64'(rdata), 64'hDEADBEEF);
    check("wr3_rd3_valid", 64'(rvalid), 64'd1);
    cyc();
    check("hold_data", 64'(rdata), 64'hDEADBEEF);
    check("hold_valid", 64'(rvalid), 64'd0);

    // Disabled write is ignored
    en = 1'b0;
    do_write(3'd2, 32'h12345678);
    en = 1'b1;
    do_read(3'd2);
    check("en0_write_dropped", 64'(rdata), 64'h0);

    // Disabled read is ignored
    en = 1'b0;
    do_read(3'd3);
    en = 1'b1;
    check("en0_read_valid", 64'(rvalid), 64'd0);
    check("en0_read_hold", 64'(rdata), 64'h0);

    // Simultaneous write and read to different addresses
    write = 1'b1; waddr = 3'd1; wdata = 32'hCAFEF00D;
    read  = 1'b1; raddr = 3'd3;
    cyc();
    write = 1'b0; read = 1'b0;
    check("wr_rd_diff_data", 64'(rdata), 64'hDEADBEEF);
    do_read(3'd1);
    check("wr_rd_diff_written", 64'(rdata), 64'hCAFEF00D);

    // Fill and clear
    for (int i = 0; i < 8; i++) begin
      do_write(3'(i), 32'h11111111 * (i + 1));
    end
    do_read(3'd7);
    check("fill_rd7", 64'(rdata), 64'h88888888);
    clear = 1'b1;
    write = 1'b1; waddr = 3'd0; wdata = 32'hFFFFFFFF;
    read  = 1'b1; raddr = 3'd4;
    cyc();
    clear = 1'b0;
    waddr = 3'd5; wdata = 32'h5A5A5A5A;
    check("clear_rd_dropped", 64'(rvalid), 64'd0);
    check("clear_busy", 64'(busy), 64'd1);
    nbusy = 0;
    while (busy && nbusy < 20) begin
      nbusy++;
      check("sweep_rvalid", 64'(rvalid), 64'd0);
      if (nbusy == 2) clear = 1'b1;
      if (nbusy == 4) begin
        write = 1'b0; read = 1'b0; clear = 1'b0;
      end
      cyc();
    end
    check("busy_cycles", 64'(nbusy), 64'd8);
    for (int i = 0; i < 8; i++) begin
      do_read(3'(i));
      check("post_clear_data", 64'(rdata), 64'h0);
      check("post_clear_valid", 64'(rvalid), 64'd1);
    end

    // Read accepted just before a clear returns pre-clear data
    do_write(3'd2, 32'h13579BDF);
    read = 1'b1; raddr = 3'd2;
    cyc();
    read = 1'b0; clear = 1'b1;
    check("pre_clear_read_data", 64'(rdata), 64'h13579BDF);
    check("pre_clear_read_valid", 64'(rvalid), 64'd1);
    cyc();
    clear = 1'b0;
    check("pre_clear_busy", 64'(busy), 64'd1);
    check("pre_clear_rvalid_drop", 64'(rvalid), 64'd0);
    wait_idle("pre_clear_sweep_end");

    // Same-address read during write
    do_write(3'd6, 32'hAAAAAAAA);
`ifdef PARAM_RAM_BYPASS_EN
    exp_bypass = 32'h55555555;
`else
    exp_bypass = 32'hAAAAAAAA;
`endif
    write = 1'b1; waddr = 3'd6; wdata = 32'h55555555;
    read  = 1'b1; raddr = 3'd6;
    cyc();
    write = 1'b0; read = 1'b0;
    check("rdw_same_addr", 64'(rdata), 64'(exp_bypass));
    do_read(3'd6);
    check("rdw_after", 64'(rdata), 64'h55555555);

    // Reset in the middle of a sweep
    do_write(3'd7, 32'h0F0F0F0F);
    do_read(3'd7);
    check("pre_abort_rd7", 64'(rdata), 64'h0F0F0F0F);
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    cyc();
    cyc();
    cyc();
    check("abort_busy_before", 64'(busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_rdata", 64'(rdata), 64'h0);
    cyc();
    rst_n = 1'b1;
    check("abort_busy_release", 64'(busy), 64'd0);
    // First edge after release accepts a write
    do_write(3'd3, 32'h24681357);
    do_read(3'd3);
    check("first_edge_write", 64'(rdata), 64'h24681357);
    for (int i = 0; i < 8; i++) begin
      if (i != 3) begin
        do_read(3'(i));
        check("post_abort_zero", 64'(rdata), 64'h0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/param_ram.md
PARAM_RAM -- requirements
Module: param_ram

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the data word width in bits (legal range 1..64).
REQ-002 The block SHALL have parameter ADDR_W, default 3, giving the address width; DEPTH = 2**ADDR_W words (default 8).
REQ-003 Port clk  input  1  is the single clock; all state updates occur on the rising edge.
REQ-004 Port rst_n  input  1  is the asynchronous, active-low reset.
REQ-005 Port en  input  1  is the global enable; when low, no read or write request is accepted.
REQ-006 Port write  input  1  is the write request.
REQ-007 Port waddr  input  ADDR_W  is the write address.
REQ-008 Port wdata  input  WIDTH  is the write data.
REQ-009 Port read  input  1  is the read request.
REQ-010 Port raddr  input  ADDR_W  is the read address.
REQ-011 Port rdata  output  WIDTH  is the registered read data.
REQ-012 Port rvalid  output  1  is high for one cycle when rdata holds the result of an accepted read.
REQ-013 Port clear  input  1  is a single-cycle request to zero the whole array.
REQ-014 Port busy  output  1  is high while a clear sweep is in progress.

Function
REQ-015 A write SHALL be accepted when en=1, write=1 and busy=0; mem[waddr] takes wdata at that edge.
REQ-016 A read SHALL be accepted when en=1, read=1 and busy=0; one cycle later rdata = mem[raddr] and rvalid=1.
REQ-017 rdata SHALL hold its last value when no read is accepted; rvalid SHALL then be 0.
REQ-018 Simultaneous write and read to different addresses SHALL both complete in the same cycle.
REQ-019 The controller SHALL have two states: IDLE and SWEEP.
REQ-020 In IDLE, clear=1 (regardless of en) SHALL move to SWEEP with sweep pointer 0, and busy SHALL be 1 from the next cycle.
REQ-021 In SWEEP, one word per cycle SHALL be zeroed at the pointer, starting at 0 and incrementing by 1.
REQ-022 The transition to IDLE SHALL occur on the edge that zeroes word DEPTH-1; busy is high for exactly DEPTH cycles.
REQ-023 In SWEEP, read, write and clear requests SHALL be ignored (dropped, not queued), and rvalid SHALL be 0.
REQ-024 When clear coincides with a write or read in IDLE, clear SHALL win and the write and read SHALL be dropped.
REQ-025 A read accepted in the cycle before the sweep starts SHALL still return its pre-clear data with rvalid=1.

Reset
REQ-026 rst_n=0 SHALL immediately force all storage words to 0, rdata=0, rvalid=0, busy=0 and the state to IDLE.
REQ-027 Reset asserted mid-sweep SHALL abort the sweep; after release the block SHALL be in IDLE with busy=0.
REQ-028 The first request SHALL be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-029 Macro PARAM_RAM_BYPASS_EN SHALL control same-address read-during-write.
REQ-030 With PARAM_RAM_BYPASS_EN defined, an accepted read and write to the same address in the same cycle SHALL return the new wdata.
REQ-031 Without PARAM_RAM_BYPASS_EN, the same case SHALL return the old stored word, and the write SHALL still complete.

Verification (WIDTH=32, ADDR_W=3)
REQ-032 Reset, then read address 5 -> rdata=0x00000000 and rvalid=1 one cycle later.
REQ-033 Write 0xDEADBEEF to address 3, then read address 3 -> rdata=0xDEADBEEF and rvalid=1 one cycle after the read.
REQ-034 Write 0x12345678 to address 2 with en=0, then read address 2 with en=1 -> rdata=0x00000000.
REQ-035 Fill addresses 0..7 with 0x11111111*(i+1), pulse clear -> busy high for 8 cycles and a concurrent write is dropped; afterward every read returns 0.
REQ-036 With address 6 holding 0xAAAAAAAA, read and write 0x55555555 to address 6 in the same cycle -> rdata=0x55555555 with the macro defined, 0xAAAAAAAA without; both builds read 0x55555555 next.
REQ-037 Pulse clear, assert rst_n=0 at sweep cycle 4, then release -> busy=0 and all words read 0.
